// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the round-robin wishbone arbiter: FSM state encoding
// and the default owner timeout.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TOUT  = 2'd2,
    ST_DRAIN = 2'd3
  } wb_arb_state_e;

  localparam int WB_ARB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority pick: first requester found scanning upward from
// (last_owner+1) mod N_MASTERS with wrap; one-hot result, zero when idle.
module wb_rr_pick #(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] last_owner,
  output logic [N_MASTERS-1:0]         pick
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!found && req[i] && (i == (int'(last_owner) + off) % N_MASTERS)) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin wishbone bus arbiter with registered one-hot grant.
// Owner timeout/abort logic is built only when WB_ARBITER_RR_TIMEOUT_EN is defined.
module wb_arbiter_rr
  import wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = WB_ARB_DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         m_cyc,
  input  logic                         s_ack,
  input  logic                         s_err,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] gnt_id,
  output logic                         gnt_vld,
  output logic                         abort,
  output logic                         to_err
);

  localparam int IW = $clog2(N_MASTERS);

  wb_arb_state_e        state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d, pick;
  logic [IW-1:0]        id_q, id_d, last_q, last_d, pick_id;
  logic                 owner_req;

  function automatic logic [IW-1:0] encode(input logic [N_MASTERS-1:0] oh);
    logic [IW-1:0] enc;
    enc = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (oh[i]) enc = IW'(i);
    end
    return enc;
  endfunction

  wb_rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .req        (m_cyc),
    .last_owner (last_q),
    .pick       (pick)
  );

  assign pick_id   = encode(pick);
  assign owner_req = m_cyc[id_q];

`ifdef WB_ARBITER_RR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_slave_resp;
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign unused_slave_resp = s_ack ^ s_err;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    abort   = 1'b0;
    to_err  = 1'b0;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|m_cyc) begin
          state_d = ST_BUSY;
          gnt_d   = pick;
          last_d  = pick_id;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUSY: begin
        // Owner release wins over a coincident timeout expiry.
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
`ifdef WB_ARBITER_RR_TIMEOUT_EN
        else if (s_ack || s_err) cnt_d = '0;
        else if (cnt_q == CNT_MAX) state_d = ST_TOUT;
        else cnt_d = cnt_q + 1'b1;
`endif
      end
`ifdef WB_ARBITER_RR_TIMEOUT_EN
      ST_TOUT: begin
        to_err  = 1'b1;
        abort   = 1'b1;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        abort = 1'b1;
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign id_d = encode(gnt_d);

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gnt_vld = |gnt_q;

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesting wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, number of owner cycles without slave ACK/ERR before abort.
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: m_cyc  input  N_MASTERS  CYC of each master; bit i is master i's request.
REQ-006 SHALL have ports: s_ack  input  1  ACK from the shared slave path.
REQ-007 SHALL have ports: s_err  input  1  ERR from the shared slave path.
REQ-008 SHALL have ports: gnt  output  N_MASTERS  one-hot grant; drives the master-to-slave mux select.
REQ-009 SHALL have ports: gnt_id  output  $clog2(N_MASTERS)  binary index of the current owner.
REQ-010 SHALL have ports: gnt_vld  output  1  a grant is active.
REQ-011 SHALL have ports: abort  output  1  forces the slave-side CYC/STB low.
REQ-012 SHALL have ports: to_err  output  1  one-cycle ERR to the owner on timeout.

Function
REQ-013 SHALL implement states IDLE, BUSY, TOUT, DRAIN, in a single registered FSM.
- IDLE: no grant.
  - Any m_cyc bit set -> BUSY.
  - Grant goes to the first requester scanning from (last_owner+1) mod N_MASTERS upward, with wrap.
  - gnt, gnt_id and gnt_vld are registered: 1-cycle latency from request to grant.
- BUSY: grant held while m_cyc[gnt_id]=1, regardless of other requests.
  - Owner's m_cyc drops -> IDLE; gnt is cleared on the next edge.
  - At least one dead cycle always separates two owners.
- TOUT: lasts exactly one cycle.
  - to_err=1 and abort=1; gnt held.
  - Next state is DRAIN.
- DRAIN: abort=1 and gnt held until m_cyc[gnt_id]=0, then -> IDLE.
REQ-014 SHALL update last_owner only on entry to BUSY.
REQ-015 SHALL use a timeout counter that:
- clears on BUSY entry and on any cycle with s_ack|s_err;
- increments otherwise while in BUSY;
- causes BUSY->TOUT when count reaches TIMEOUT_CYCLES-1 with no ACK/ERR that cycle.
REQ-016 SHALL give priority to the owner dropping m_cyc over timeout expiry when both occur in the same cycle (-> IDLE, no to_err).
REQ-017 SHALL keep gnt one-hot or zero at all times; gnt_vld = |gnt; gnt_id = encode(gnt), 0 when gnt_vld=0.
REQ-018 SHALL treat a new request from the just-released owner as lowest priority in the next IDLE arbitration.
REQ-019 SHALL set abort=0 and to_err=0 in IDLE and BUSY.

Reset
REQ-020 SHALL, while rst=1, asynchronously force:
- state=IDLE; gnt=0, gnt_id=0, gnt_vld=0, abort=0, to_err=0;
- counter=0;
- last_owner=N_MASTERS-1, so master 0 wins first.
REQ-021 SHALL, on rst asserted mid-transaction, drop the grant immediately, with no to_err pulse.

Configuration
REQ-022 SHALL compile the timeout logic (counter, TOUT, DRAIN, to_err, abort) only when macro WB_ARBITER_RR_TIMEOUT_EN is defined.
- Without the macro: abort and to_err are tied 0.
- Without the macro: BUSY is left only by the owner dropping m_cyc.
- Without the macro: TIMEOUT_CYCLES is ignored.

Structure
REQ-023 SHALL place the FSM state enum typedef (wb_arb_state_e) and the default timeout constant in shared package wb_arbiter_pkg.
REQ-024 SHALL implement the rotating-priority selection as sub-module wb_rr_pick (combinational: request vector + last_owner -> one-hot pick).

Verification
REQ-025 SHALL cover a single request: m_cyc=01 from reset -> gnt=01, gnt_id=0 one cycle later; m_cyc=00 -> gnt=00 next cycle.
REQ-026 SHALL cover contention fairness (N_MASTERS=2): m_cyc=11 held, each owner releases after 4 cycles -> grants alternate 01,10,01,10 with one idle cycle between.
REQ-027 SHALL cover wrap (N_MASTERS=4): last_owner=3, m_cyc=1001 -> grant to master 0; next arbitration with m_cyc=1001 -> master 3.
REQ-028 SHALL cover timeout (macro on, TIMEOUT_CYCLES=8): owner holds m_cyc, no ACK -> to_err high exactly on the 9th cycle after grant; abort high until m_cyc drops; then IDLE.
REQ-029 SHALL cover ACK keep-alive: s_ack every 5 cycles, TIMEOUT_CYCLES=8 -> no to_err over 100 cycles.
REQ-030 SHALL cover reset mid-BUSY: rst pulse while gnt=10 -> gnt=00 asynchronously; first post-reset grant goes to master 0 when m_cyc=11.
